spi_cmd_decoder: RTL and testbench

//  Frame-level command decoder between spi_slave and MemoryMap/StorageLayer. Consumes 16-bit

---
 rtl/spi_cmd_decoder.sv | 183 ++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// Frame-level SPI command decoder. It turns chip-select framed 16-bit words into register
// write bursts, enable set/clear pulses, or FIFO pops whose data is returned for MISO.
module spi_cmd_decoder #(
    parameter int          ADDR_W    = 8,
    parameter int          REG_COUNT = 16,
    parameter logic [15:0] C_MEM_WR  = 16'h0001,
    parameter logic [15:0] C_MEM_RD  = 16'h0002,
    parameter logic [15:0] C_EN_SET  = 16'h0003,
    parameter logic [15:0] C_EN_CLR  = 16'h0004
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csn_sync,
    input  logic [15:0]       word_in,
    input  logic              word_valid,
    input  logic [15:0]       fifo_data,
    input  logic              fifo_empty,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [15:0]       reg_wdata,
    output logic              reg_we,
    output logic              en_set,
    output logic              en_clr,
    output logic              fifo_rd,
    output logic [15:0]       tx_word,
    output logic              tx_load,
    output logic              cmd_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DISCARD
    } state_t;

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(REG_COUNT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [15:0]       reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              en_set_q, en_set_d;
    logic              en_clr_q, en_clr_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              rd_miss_q, rd_miss_d;
    logic              tx_load_q, tx_load_d;
    logic              tx_miss_q, tx_miss_d;
    logic [15:0]       tx_word_q, tx_word_d;
    logic              cmd_err_q, cmd_err_d;
    logic              busy_q, busy_d;
    logic              rearm_q, rearm_d;
    logic              accept;

    // Popped data is only valid in the cycle after fifo_rd, so the load cycle passes it
    // straight through and the holding register keeps it stable afterwards.
    assign tx_word   = tx_load_q ? (tx_miss_q ? 16'h0000 : fifo_data) : tx_word_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign en_set    = en_set_q;
    assign en_clr    = en_clr_q;
    assign fifo_rd   = fifo_rd_q;
    assign tx_load   = tx_load_q;
    assign cmd_err   = cmd_err_q;
    assign busy      = busy_q;

    always_comb begin
        accept      = word_valid && !csn_sync;
        state_d     = state_q;
        cnt_d       = cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        en_set_d    = 1'b0;
        en_clr_d    = 1'b0;
        fifo_rd_d   = 1'b0;
        rd_miss_d   = 1'b0;
        rearm_d     = rearm_q;
        // Read pipeline second stage runs regardless of chip select so a pending pop completes.
        tx_load_d   = fifo_rd_q || rd_miss_q;
        tx_miss_d   = rd_miss_q;
        cmd_err_d   = rd_miss_q;
        tx_word_d   = tx_word;

        if (csn_sync) begin
            state_d = S_IDLE;
            rearm_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rearm_q) state_d = S_CMD;
                end
                S_CMD: begin
                    if (accept) begin
                        if (word_in == C_MEM_WR) begin
                            state_d = S_ADDR;
                        end else if (word_in == C_MEM_RD) begin
                            state_d = S_RDATA;
                        end else if (word_in == C_EN_SET) begin
                            en_set_d = 1'b1;
                            state_d  = S_DISCARD;
                        end else if (word_in == C_EN_CLR) begin
                            en_clr_d = 1'b1;
                            state_d  = S_DISCARD;
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = S_DISCARD;
                        end
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        cnt_d   = word_in[ADDR_W-1:0];
                        state_d = S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (accept) begin
                        if ({1'b0, cnt_q} < REG_LIMIT) begin
                            reg_we_d    = 1'b1;
                            reg_addr_d  = cnt_q;
                            reg_wdata_d = word_in;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                S_RDATA: begin
                    if (accept) begin
                        fifo_rd_d = !fifo_empty;
                        rd_miss_d = fifo_empty;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // After reset the chip select must go high once before a new frame is decoded.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            en_set_q    <= 1'b0;
            en_clr_q    <= 1'b0;
            fifo_rd_q   <= 1'b0;
            rd_miss_q   <= 1'b0;
            tx_load_q   <= 1'b0;
            tx_miss_q   <= 1'b0;
            tx_word_q   <= '0;
            cmd_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            rearm_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            en_set_q    <= en_set_d;
            en_clr_q    <= en_clr_d;
            fifo_rd_q   <= fifo_rd_d;
            rd_miss_q   <= rd_miss_d;
            tx_load_q   <= tx_load_d;
            tx_miss_q   <= tx_miss_d;
            tx_word_q   <= tx_word_d;
            cmd_err_q   <= cmd_err_d;
            busy_q      <= busy_d;
            rearm_q     <= rearm_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: frames of words with hand-computed expected outputs,
// a small FIFO model, and an event log sampled on the falling clock edge.
module tb_spi_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        csn_sync;
    logic [15:0] word_in;
    logic        word_valid;
    logic [15:0] fifo_data = 16'h0000;
    logic        fifo_empty;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        en_set;
    logic        en_clr;
    logic        fifo_rd;
    logic [15:0] tx_word;
    logic        tx_load;
    logic        cmd_err;
    logic        busy;

    spi_cmd_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .csn_sync   (csn_sync),
        .word_in    (word_in),
        .word_valid (word_valid),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .en_set     (en_set),
        .en_clr     (en_clr),
        .fifo_rd    (fifo_rd),
        .tx_word    (tx_word),
        .tx_load    (tx_load),
        .cmd_err    (cmd_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO_OUT model: read data appears the cycle after the pop strobe.
    logic [15:0] fmem [0:7];
    int wptr = 0;
    int rptr = 0;
    assign fifo_empty = (rptr == wptr);
    always @(posedge clk) begin
        if (fifo_rd && rptr < wptr) begin
            fifo_data <= fmem[rptr];
            rptr <= rptr + 1;
        end
    end

    logic [63:0] outs;
    assign outs = {17'd0, reg_addr, reg_wdata, reg_we, en_set, en_clr, fifo_rd,
                   tx_word, tx_load, cmd_err, busy};

    // Event log
    int          wr_addr [$];
    logic [15:0] wr_data [$];
    int          wr_cyc  [$];
    int          set_cyc [$];
    int          clr_cyc [$];
    int          rd_cyc  [$];
    int          err_cyc [$];
    logic [15:0] tx_val  [$];
    int          tx_cyc  [$];
    int          wv_q    [$];

    always @(negedge clk) begin
        if (reg_we) begin
            wr_addr.push_back(int'(reg_addr));
            wr_data.push_back(reg_wdata);
            wr_cyc.push_back(cyc);
        end
        if (en_set)  set_cyc.push_back(cyc);
        if (en_clr)  clr_cyc.push_back(cyc);
        if (fifo_rd) rd_cyc.push_back(cyc);
        if (cmd_err) err_cyc.push_back(cyc);
        if (tx_load) begin
            tx_val.push_back(tx_word);
            tx_cyc.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int b_wr, b_set, b_clr, b_rd, b_err, b_tx, b_wv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic mark();
        b_wr  = wr_addr.size();
        b_set = set_cyc.size();
        b_clr = clr_cyc.size();
        b_rd  = rd_cyc.size();
        b_err = err_cyc.size();
        b_tx  = tx_val.size();
        b_wv  = wv_q.size();
    endtask

    task automatic send(input logic [15:0] w);
        @(posedge clk); #1;
        word_in    = w;
        word_valid = 1'b1;
        wv_q.push_back(cyc);
        @(posedge clk); #1;
        word_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic frame_start();
        @(posedge clk); #1;
        csn_sync = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic frame_end();
        @(posedge clk); #1;
        csn_sync = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        csn_sync   = 1'b1;
        word_valid = 1'b0;
        word_in    = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // T1: single register write, busy drops one cycle after csn high
        mark();
        frame_start();
        send(16'h0001); send(16'h0004); send(16'h8207);
        @(negedge clk);
        check("t1_busy_in_frame", 64'(busy), 64'd1);
        @(posedge clk); #1;
        csn_sync = 1'b1;
        @(negedge clk);
        check("t1_busy_csn_cycle", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_busy_after", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        check("t1_wr_count", 64'(wr_addr.size() - b_wr), 64'd1);
        check("t1_wr_addr", 64'(wr_addr[b_wr]), 64'd4);
        check("t1_wr_data", 64'(wr_data[b_wr]), 64'h8207);
        check("t1_wr_latency", 64'(wr_cyc[b_wr] - wv_q[b_wv + 2]), 64'd1);
        check("t1_err_count", 64'(err_cyc.size() - b_err), 64'd0);

        // T2: auto-increment burst, then overrun past the last implemented register
        mark();
        frame_start();
        send(16'h0001); send(16'h0008);
        for (int i = 0; i < 6; i++) send(16'h0000);
        frame_end();
        check("t2a_wr_count", 64'(wr_addr.size() - b_wr), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t2a_wr_addr%0d", i), 64'(wr_addr[b_wr + i]), 64'(8 + i));
        check("t2a_wr_data", 64'(wr_data[b_wr + 5]), 64'd0);
        mark();
        frame_start();
        send(16'h0001); send(16'h000E);
        for (int i = 0; i < 3; i++) send(16'h0000);
        frame_end();
        check("t2b_wr_count", 64'(wr_addr.size() - b_wr), 64'd2);
        check("t2b_wr_addr0", 64'(wr_addr[b_wr]), 64'd14);
        check("t2b_wr_addr1", 64'(wr_addr[b_wr + 1]), 64'd15);
        check("t2b_err_count", 64'(err_cyc.size() - b_err), 64'd1);
        if (err_cyc.size() > b_err)
            check("t2b_err_latency", 64'(err_cyc[b_err] - wv_q[b_wv + 4]), 64'd1);

        // T3: enable set, then enable clear with a trailing word
        mark();
        frame_start();
        send(16'h0003);
        frame_end();
        frame_start();
        send(16'h0004); send(16'hFFFF);
        frame_end();
        check("t3_set_count", 64'(set_cyc.size() - b_set), 64'd1);
        check("t3_clr_count", 64'(clr_cyc.size() - b_clr), 64'd1);
        if (set_cyc.size() > b_set)
            check("t3_set_latency", 64'(set_cyc[b_set] - wv_q[b_wv]), 64'd1);
        check("t3_wr_count", 64'(wr_addr.size() - b_wr), 64'd0);
        check("t3_err_count", 64'(err_cyc.size() - b_err), 64'd0);

        // T4: FIFO read burst with an empty-FIFO underrun on the third word
        fmem[0] = 16'h0A0B;
        fmem[1] = 16'h0C0D;
        wptr    = 2;
        mark();
        frame_start();
        send(16'h0002); send(16'h0000); send(16'h0000); send(16'h0000);
        frame_end();
        check("t4_rd_count", 64'(rd_cyc.size() - b_rd), 64'd2);
        check("t4_tx_count", 64'(tx_val.size() - b_tx), 64'd3);
        if (tx_val.size() >= b_tx + 3) begin
            check("t4_tx0", 64'(tx_val[b_tx]), 64'h0A0B);
            check("t4_tx1", 64'(tx_val[b_tx + 1]), 64'h0C0D);
            check("t4_tx2", 64'(tx_val[b_tx + 2]), 64'h0000);
            check("t4_tx_latency", 64'(tx_cyc[b_tx] - wv_q[b_wv + 1]), 64'd2);
        end
        if (rd_cyc.size() > b_rd)
            check("t4_rd_latency", 64'(rd_cyc[b_rd] - wv_q[b_wv + 1]), 64'd1);
        check("t4_err_count", 64'(err_cyc.size() - b_err), 64'd1);
        if (err_cyc.size() > b_err)
            check("t4_err_latency", 64'(err_cyc[b_err] - wv_q[b_wv + 3]), 64'd2);

        // T5: unknown command, then an aborted write frame followed by a clean one
        mark();
        frame_start();
        send(16'h00FF); send(16'h0001);
        frame_end();
        check("t5_bad_err_count", 64'(err_cyc.size() - b_err), 64'd1);
        frame_start();
        send(16'h0001); send(16'h0005);
        frame_end();
        frame_start();
        send(16'h0001); send(16'h0003); send(16'hBEEF);
        frame_end();
        check("t5_wr_count", 64'(wr_addr.size() - b_wr), 64'd1);
        if (wr_addr.size() > b_wr) begin
            check("t5_wr_addr", 64'(wr_addr[b_wr]), 64'd3);
            check("t5_wr_data", 64'(wr_data[b_wr]), 64'hBEEF);
        end

        // T6: reset one cycle after the address word of a write frame
        mark();
        frame_start();
        send(16'h0001);
        @(posedge clk); #1;
        word_in    = 16'h0007;
        word_valid = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clk); #1;
        word_in    = 16'h5555;
        word_valid = 1'b1;
        @(negedge clk);
        check("t6_outs_reset0", outs, 64'd0);
        @(posedge clk); #1;
        word_valid = 1'b0;
        @(negedge clk);
        check("t6_outs_reset1", outs, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        send(16'h0001); send(16'h0009); send(16'h7777);
        @(negedge clk);
        check("t6_busy_no_rearm", 64'(busy), 64'd0);
        frame_end();
        check("t6_wr_none", 64'(wr_addr.size() - b_wr), 64'd0);
        frame_start();
        send(16'h0001); send(16'h0002); send(16'h4242);
        frame_end();
        check("t6_wr_count", 64'(wr_addr.size() - b_wr), 64'd1);
        if (wr_addr.size() > b_wr) begin
            check("t6_wr_addr", 64'(wr_addr[b_wr]), 64'd2);
            check("t6_wr_data", 64'(wr_data[b_wr]), 64'h4242);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
